daa_ctrl: RTL
=============

DAA_CTRL -- requirements
Module: daa_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 1024, max cycles per job without i_daa_finished before abort.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_start  input  1  host request; sampled only in IDLE.
REQ-005 i_pointx, i_pointy  input  256 each  base point P.
REQ-006 i_prime, i_a, i_b  input  256 each  curve field prime and coefficients.
REQ-007 i_m, i_n  input  256 each  scalars m and n.
REQ-008 daa_mode  output  2  constant 2'b00 (scalar multiply).
REQ-009 daa_valid  output  1  job active toward the point-multiply unit.
REQ-010 o_daa_pointx, o_daa_pointy, o_daa_prime, o_daa_a, o_daa_b, o_daa_mul  output  256 each  operands to the point-multiply unit.
REQ-011 i_daa_finished  input  1  result-valid strobe from the point-multiply unit.
REQ-012 i_daa_outputx, i_daa_outputy  input  256 each  result point.
REQ-013 o_busy  output  1  high in any state except IDLE.
REQ-014 o_done  output  1  one-cycle completion pulse.
REQ-015 o_error  output  1  one-cycle timeout pulse, coincident with o_done.
REQ-016 o_mPx, o_mPy, o_mnPx, o_mnPy  output  256 each  captured results mP and n(mP).

Function
REQ-017 FSM states: IDLE, JOB1, JOB2, DONE.
REQ-018 IDLE with i_start=1: latch i_pointx/y, i_prime, i_a, i_b, i_m, i_n; next state JOB1; i_start while o_busy=1 ignored.
REQ-019 daa_valid = 1 exactly when state is JOB1 or JOB2; first daa_valid cycle is the cycle after i_start is sampled.
REQ-020 JOB1 operands: latched P, prime, a, b; o_daa_mul = latched m.
REQ-021 JOB1 with i_daa_finished=1: capture i_daa_outputx/y into o_mPx/o_mPy; next state JOB2; daa_valid stays high across the transition.
REQ-022 JOB2 operands: point = o_mPx/o_mPy, same prime/a/b, o_daa_mul = latched n.
REQ-023 JOB2 with i_daa_finished=1: capture into o_mnPx/o_mnPy; next state DONE.
REQ-024 DONE: o_done=1 for one cycle; next state IDLE; new i_start accepted from the following cycle.
REQ-025 Watchdog counter, width ceil(log2(TIMEOUT))+1: cleared on entry to JOB1 and JOB2, increments each job cycle; i_daa_finished absent at count TIMEOUT-1 -> o_done=1 and o_error=1 that cycle, next state IDLE, current job's result registers unchanged.
REQ-026 Finished and timeout in the same cycle: finished wins, no error.
REQ-027 i_daa_finished in IDLE or DONE ignored; no register update.
REQ-028 Result registers hold value until overwritten by a later capture; outside JOB1/JOB2 the operand outputs hold their last values.
REQ-029 Per-transaction latency: 1 + L1 + L2 + 1 cycles from i_start to o_done, Lk = cycles in job k including its finished cycle.

Reset
REQ-030 rst=1 at a rising edge: state IDLE; watchdog, all latched operands and all result registers 0; o_busy, o_done, o_error, daa_valid 0 from that edge.
REQ-031 rst mid-JOB1/JOB2: job aborted, daa_valid low after the edge, no o_done, no o_error; reset dominates i_start and i_daa_finished in the same cycle.

Verification
REQ-032 Nominal: i_start, P=(1,2), m=5, n=7; stub finishes JOB1 after 33 cycles with (32'hDFA978E7, 32'hF6A1A9BB), JOB2 after 65 with (32'h888F3531, 32'h71917832) -> o_mP*/o_mnP* equal those, o_done once, o_error 0, JOB2 o_daa_pointx = 32'hDFA978E7, o_daa_mul = 7.
REQ-033 Timeout: TIMEOUT=16, stub never finishes -> o_done=o_error=1 on 16th JOB1 cycle, results stay 0, o_busy=0 next cycle.
REQ-034 Finished on the last watchdog cycle -> capture, JOB2 entered, o_error 0.
REQ-035 i_start pulsed during JOB1 and a spurious i_daa_finished in IDLE -> no effect on latched operands, state, or results.
REQ-036 rst asserted midway through JOB2 -> next cycle all outputs 0, state IDLE; fresh i_start completes normally.
REQ-037 Back-to-back: i_start in the cycle after o_done -> accepted, daa_valid high the following cycle.

Source files
------------

// File: rtl/daa_ctrl.sv
// Double-and-add sequencer: computes mP and then n(mP) by issuing two scalar
// multiplies to an external point-multiply unit, each guarded by a watchdog.
module daa_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [255:0] i_pointx,
  input  logic [255:0] i_pointy,
  input  logic [255:0] i_prime,
  input  logic [255:0] i_a,
  input  logic [255:0] i_b,
  input  logic [255:0] i_m,
  input  logic [255:0] i_n,
  output logic [1:0]   daa_mode,
  output logic         daa_valid,
  output logic [255:0] o_daa_pointx,
  output logic [255:0] o_daa_pointy,
  output logic [255:0] o_daa_prime,
  output logic [255:0] o_daa_a,
  output logic [255:0] o_daa_b,
  output logic [255:0] o_daa_mul,
  input  logic         i_daa_finished,
  input  logic [255:0] i_daa_outputx,
  input  logic [255:0] i_daa_outputy,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_error,
  output logic [255:0] o_mPx,
  output logic [255:0] o_mPy,
  output logic [255:0] o_mnPx,
  output logic [255:0] o_mnPy
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, JOB1, JOB2, DONE} state_t;

  state_t       state_q;
  logic [CW-1:0] wdog_q;
  logic [255:0] n_q;
  logic [255:0] pointx_q, pointy_q, prime_q, a_q, b_q, mul_q;
  logic [255:0] mpx_q, mpy_q, mnpx_q, mnpy_q;

  logic in_job;
  logic last_cycle;
  logic timeout;

  assign in_job     = (state_q == JOB1) || (state_q == JOB2);
  assign last_cycle = in_job && (wdog_q == CW'(TIMEOUT - 1));
  // A finish on the last watchdog cycle still counts; reset suppresses the abort pulse.
  assign timeout    = last_cycle && !i_daa_finished && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wdog_q   <= '0;
      n_q      <= '0;
      pointx_q <= '0;
      pointy_q <= '0;
      prime_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mul_q    <= '0;
      mpx_q    <= '0;
      mpy_q    <= '0;
      mnpx_q   <= '0;
      mnpy_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            pointx_q <= i_pointx;
            pointy_q <= i_pointy;
            prime_q  <= i_prime;
            a_q      <= i_a;
            b_q      <= i_b;
            mul_q    <= i_m;
            n_q      <= i_n;
            wdog_q   <= '0;
            state_q  <= JOB1;
          end
        end
        JOB1: begin
          if (i_daa_finished) begin
            // mP becomes both a result and the base point of the second job.
            mpx_q    <= i_daa_outputx;
            mpy_q    <= i_daa_outputy;
            pointx_q <= i_daa_outputx;
            pointy_q <= i_daa_outputy;
            mul_q    <= n_q;
            wdog_q   <= '0;
            state_q  <= JOB2;
          end else if (last_cycle) begin
            state_q <= IDLE;
          end else begin
            wdog_q <= wdog_q + CW'(1);
          end
        end
        JOB2: begin
          if (i_daa_finished) begin
            mnpx_q  <= i_daa_outputx;
            mnpy_q  <= i_daa_outputy;
            state_q <= DONE;
          end else if (last_cycle) begin
            state_q <= IDLE;
          end else begin
            wdog_q <= wdog_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign daa_mode     = 2'b00;
  assign daa_valid    = in_job;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE) || timeout;
  assign o_error      = timeout;
  assign o_daa_pointx = pointx_q;
  assign o_daa_pointy = pointy_q;
  assign o_daa_prime  = prime_q;
  assign o_daa_a      = a_q;
  assign o_daa_b      = b_q;
  assign o_daa_mul    = mul_q;
  assign o_mPx        = mpx_q;
  assign o_mPy        = mpy_q;
  assign o_mnPx       = mnpx_q;
  assign o_mnPy       = mnpy_q;

endmodule
